// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with next-PC arbitration between predicted PC, ID-stage JAL and EX redirects.
// Define BPU_PERF_CNT_EN to build the resolved-branch / mispredict performance counters.
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter logic [1:0]  CNT_INIT     = 2'b01,
  parameter int unsigned CTR_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  input  logic                 fetch_is_br,
  input  logic [PC_WIDTH-1:0]  fetch_br_target,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_pc,
  input  logic                 id_is_jal,
  input  logic [PC_WIDTH-1:0]  id_jal_target,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic                 ex_is_br,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [PC_WIDTH-1:0]  ex_br_target,
  input  logic [PC_WIDTH-1:0]  ex_jalr_target,
  input  logic                 BrEq,
  input  logic                 BrLt,
  output logic [1:0]           PCSel,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic [CTR_WIDTH-1:0] br_count,
  output logic [CTR_WIDTH-1:0] mispred_count
);

  localparam int unsigned         BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4);
  localparam logic [1:0]          PCSEL_PRED  = 2'b00;
  localparam logic [1:0]          PCSEL_JAL   = 2'b01;
  localparam logic [1:0]          PCSEL_REDIR = 2'b10;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) res = 2'b11;
      else              res = cnt + 2'b01;
    end else begin
      if (cnt == 2'b00) res = 2'b00;
      else              res = cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]              bht_q [BHT_ENTRIES];
  logic [1:0]              bht_d [BHT_ENTRIES];
  logic [BHT_IDX_BITS-1:0] fetch_idx_s;
  logic [BHT_IDX_BITS-1:0] ex_idx_s;
  logic                    fetch_hit_s;
  logic                    br_legal_s;
  logic                    br_taken_s;
  logic                    br_valid_s;
  logic                    resolve_s;
  logic                    br_mispred_s;
  logic                    jalr_redir_s;
  logic                    ex_redirect_s;

  assign fetch_idx_s = fetch_pc[BHT_IDX_BITS+1:2];
  assign ex_idx_s    = ex_pc[BHT_IDX_BITS+1:2];
  assign fetch_hit_s = fetch_is_br & bht_q[fetch_idx_s][1];

  always_comb begin
    br_legal_s = 1'b1;
    br_taken_s = 1'b0;
    case (ex_funct3)
      3'b000:         br_taken_s = BrEq;
      3'b001:         br_taken_s = ~BrEq;
      3'b100, 3'b110: br_taken_s = BrLt;
      3'b101, 3'b111: br_taken_s = ~BrLt;
      default:        br_legal_s = 1'b0;
    endcase
  end

  // Redirects follow ex_valid only, so they persist while EX is stalled; training does not.
  assign br_valid_s    = ex_valid & ex_is_br & br_legal_s;
  assign resolve_s     = br_valid_s & ~ex_stall;
  assign br_mispred_s  = br_valid_s & (br_taken_s != ex_pred_taken);
  assign jalr_redir_s  = ex_valid & ex_is_jalr;
  assign ex_redirect_s = jalr_redir_s | br_mispred_s;

  always_comb begin
    pred_taken  = 1'b0;
    pred_pc     = fetch_pc + PC_STEP;
    PCSel       = PCSEL_PRED;
    flush       = 1'b0;
    redirect_pc = '0;
    if (rst) begin
      pred_taken  = 1'b0;
      pred_pc     = fetch_pc + PC_STEP;
      PCSel       = PCSEL_PRED;
      flush       = 1'b0;
      redirect_pc = '0;
    end else begin
      pred_taken = fetch_hit_s;
      if (fetch_hit_s) pred_pc = fetch_br_target;
      else             pred_pc = fetch_pc + PC_STEP;
      if (jalr_redir_s) begin
        redirect_pc = ex_jalr_target;
      end else if (br_mispred_s) begin
        if (br_taken_s) redirect_pc = ex_br_target;
        else            redirect_pc = ex_pc + PC_STEP;
      end else begin
        redirect_pc = '0;
      end
      if (ex_redirect_s) begin
        PCSel = PCSEL_REDIR;
        flush = 1'b1;
      end else if (id_is_jal) begin
        PCSel = PCSEL_JAL;
        flush = 1'b0;
      end else begin
        PCSel = PCSEL_PRED;
        flush = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_d[i] = bht_q[i];
    if (resolve_s) bht_d[ex_idx_s] = cnt_next(bht_q[ex_idx_s], br_taken_s);
    else           bht_d[ex_idx_s] = bht_q[ex_idx_s];
  end

  // Fetch reads bht_q, so a same-cycle update at the fetch index is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= CNT_INIT;
    end else begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= bht_d[i];
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [CTR_WIDTH-1:0] br_count_q;
  logic [CTR_WIDTH-1:0] br_count_d;
  logic [CTR_WIDTH-1:0] mispred_count_q;
  logic [CTR_WIDTH-1:0] mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (resolve_s) begin
      br_count_d = br_count_q + CTR_WIDTH'(1);
      if (br_mispred_s) mispred_count_d = mispred_count_q + CTR_WIDTH'(1);
      else              mispred_count_d = mispred_count_q;
    end else begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic
// checked against a counter-table reference model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc, fetch_br_target, id_jal_target;
  logic [31:0] ex_pc, ex_br_target, ex_jalr_target;
  logic        fetch_is_br, id_is_jal, ex_valid, ex_stall, ex_is_br, ex_is_jalr;
  logic        ex_pred_taken, BrEq, BrLt;
  logic [2:0]  ex_funct3;
  logic        pred_taken, flush;
  logic [31:0] pred_pc, redirect_pc, br_count, mispred_count;
  logic [1:0]  PCSel;

  int errors = 0;
  int checks = 0;
  int m_cnt [64];
  int m_br = 0;
  int m_mis = 0;

  logic        e_pred, e_flush, e_redir;
  logic [31:0] e_ppc, e_rpc, e_brc, e_mis;
  logic [1:0]  e_sel;

  branch_predict_unit dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .fetch_is_br(fetch_is_br), .fetch_br_target(fetch_br_target),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .id_is_jal(id_is_jal), .id_jal_target(id_jal_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_br(ex_is_br), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_br_target(ex_br_target), .ex_jalr_target(ex_jalr_target),
    .BrEq(BrEq), .BrLt(BrLt),
    .PCSel(PCSel), .redirect_pc(redirect_pc), .flush(flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  // funct3 bit 2 picks the comparator (eq / lt), bit 0 inverts the sense; 010/011 are not branches.
  task automatic m_outcome(input logic [2:0] f3, input logic eq, input logic lt,
                           output logic legal, output logic taken);
    logic base;
    legal = (f3 != 3'd2) && (f3 != 3'd3);
    base  = f3[2] ? lt : eq;
    taken = f3[0] ? !base : base;
  endtask

  task automatic m_expect();
    logic legal, taken;
    m_outcome(ex_funct3, BrEq, BrLt, legal, taken);
    e_pred  = !rst && fetch_is_br && (m_cnt[m_idx(fetch_pc)] >= 2);
    e_ppc   = e_pred ? fetch_br_target : fetch_pc + 32'd4;
    e_redir = !rst && ex_valid && (ex_is_jalr || (ex_is_br && legal && (taken != ex_pred_taken)));
    e_rpc   = ex_is_jalr ? ex_jalr_target : (taken ? ex_br_target : ex_pc + 32'd4);
    e_sel   = rst ? 2'd0 : (e_redir ? 2'd2 : (id_is_jal ? 2'd1 : 2'd0));
    e_flush = e_redir;
`ifdef BPU_PERF_CNT_EN
    e_brc = 32'(m_br);
    e_mis = 32'(m_mis);
`else
    e_brc = 32'd0;
    e_mis = 32'd0;
`endif
  endtask

  task automatic m_tick();
    logic legal, taken;
    int   i;
    m_outcome(ex_funct3, BrEq, BrLt, legal, taken);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 64; k++) m_cnt[k] = 1;
      m_br  = 0;
      m_mis = 0;
    end else if (ex_valid && !ex_stall && ex_is_br && legal) begin
      i = m_idx(ex_pc);
      if (taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
      else       m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      m_br++;
      if (taken != ex_pred_taken) m_mis++;
    end
    #1;
  endtask

  task automatic idle();
    fetch_pc = 32'd0; fetch_is_br = 1'b0; fetch_br_target = 32'd0;
    id_is_jal = 1'b0; id_jal_target = 32'd0;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_is_br = 1'b0; ex_is_jalr = 1'b0;
    ex_funct3 = 3'd0; ex_pred_taken = 1'b0; ex_pc = 32'd0;
    ex_br_target = 32'd0; ex_jalr_target = 32'd0; BrEq = 1'b0; BrLt = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    fetch_is_br = 1'b1; fetch_pc = 32'h40; fetch_br_target = 32'h80;
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_jalr_target = 32'h500; id_is_jal = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got=%b exp=0", pred_taken); end
    checks++; if (PCSel !== 2'd0) begin errors++; $display("FAIL rst_pcsel got=%0d exp=0", PCSel); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", flush); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL rst_redirect got=%h exp=0", redirect_pc); end
    m_tick();
    m_tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'h1000 | 32'(i * 4); fetch_is_br = 1'b1; fetch_br_target = fetch_pc + 32'h40;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_pc !== fetch_pc + 32'd4) begin
        errors++; $display("FAIL rst_scan idx=%0d got=%b/%h exp=0/%h", i, pred_taken, pred_pc, fetch_pc + 32'd4);
      end
    end
    checks++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
  endtask

  task automatic test_train_beq();
    logic exp_pt [3];
    exp_pt[0] = 1'b0; exp_pt[1] = 1'b1; exp_pt[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      fetch_pc = 32'h100; fetch_is_br = 1'b1; fetch_br_target = 32'h180;
      ex_valid = 1'b1; ex_is_br = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1;
      ex_pc = 32'h100; ex_br_target = 32'h180; ex_pred_taken = exp_pt[k];
      #1;
      checks++; if (pred_taken !== exp_pt[k] || pred_pc !== (exp_pt[k] ? 32'h180 : 32'h104)) begin
        errors++; $display("FAIL beq_pred k=%0d got=%b/%h exp=%b", k, pred_taken, pred_pc, exp_pt[k]);
      end
      checks++; if (flush !== (k == 0) || PCSel !== ((k == 0) ? 2'd2 : 2'd0)) begin
        errors++; $display("FAIL beq_mispredict k=%0d got=flush %b sel %0d", k, flush, PCSel);
      end
      if (k == 0) begin
        checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL beq_redirect got=%h exp=180", redirect_pc); end
      end
      m_tick();
    end
    idle(); fetch_pc = 32'h100; fetch_is_br = 1'b1; fetch_br_target = 32'h180;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_final_pred got=%b exp=1", pred_taken); end
  endtask

  task automatic test_mispredict_bne();
    logic exp_after [2];
    exp_after[0] = 1'b1; exp_after[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle();
      ex_valid = 1'b1; ex_is_br = 1'b1; ex_funct3 = 3'b001; BrEq = 1'b1; ex_pred_taken = 1'b1;
      ex_pc = 32'h100; ex_br_target = 32'h180;
      #1;
      checks++; if (PCSel !== 2'd2 || flush !== 1'b1 || redirect_pc !== 32'h104) begin
        errors++; $display("FAIL bne_redirect k=%0d got=sel %0d flush %b pc %h exp=2 1 104", k, PCSel, flush, redirect_pc);
      end
      m_tick();
      idle(); fetch_pc = 32'h100; fetch_is_br = 1'b1; fetch_br_target = 32'h180;
      #1;
      checks++; if (pred_taken !== exp_after[k]) begin
        errors++; $display("FAIL bne_decrement k=%0d got=%b exp=%b", k, pred_taken, exp_after[k]);
      end
    end
  endtask

  task automatic test_jal_jalr();
    idle();
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_jalr_target = 32'h2000;
    id_is_jal = 1'b1; id_jal_target = 32'h3000;
    #1;
    checks++; if (PCSel !== 2'd2 || redirect_pc !== 32'h2000 || flush !== 1'b1) begin
      errors++; $display("FAIL jalr_over_jal got=sel %0d pc %h flush %b exp=2 2000 1", PCSel, redirect_pc, flush);
    end
    ex_stall = 1'b1; #1;
    checks++; if (PCSel !== 2'd2 || flush !== 1'b1) begin
      errors++; $display("FAIL jalr_stalled got=sel %0d flush %b exp=2 1", PCSel, flush);
    end
    m_tick();
    ex_stall = 1'b0; ex_valid = 1'b0; #1;
    checks++; if (PCSel !== 2'd1 || flush !== 1'b0) begin
      errors++; $display("FAIL jal_only got=sel %0d flush %b exp=1 0", PCSel, flush);
    end
    m_tick();
  endtask

  task automatic test_stall();
    logic [31:0] br0, mis0;
    br0 = br_count; mis0 = mispred_count;
    for (int k = 0; k < 4; k++) begin
      idle();
      fetch_pc = 32'h220; fetch_is_br = 1'b1; fetch_br_target = 32'h2a0;
      ex_valid = 1'b1; ex_stall = (k < 3); ex_is_br = 1'b1; ex_funct3 = 3'b100; BrLt = 1'b1;
      ex_pred_taken = 1'b0; ex_pc = 32'h220; ex_br_target = 32'h2a0;
      #1;
      checks++; if (PCSel !== 2'd2 || flush !== 1'b1 || redirect_pc !== 32'h2a0 || pred_taken !== 1'b0) begin
        errors++; $display("FAIL blt_stall k=%0d got=sel %0d flush %b pc %h pt %b exp=2 1 2a0 0", k, PCSel, flush, redirect_pc, pred_taken);
      end
      m_tick();
    end
    idle(); fetch_pc = 32'h220; fetch_is_br = 1'b1; fetch_br_target = 32'h2a0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL blt_trained got=%b exp=1", pred_taken); end
`ifdef BPU_PERF_CNT_EN
    checks++; if (br_count !== br0 + 32'd1 || mispred_count !== mis0 + 32'd1) begin
      errors++; $display("FAIL blt_counters got=%0d/%0d exp=%0d/%0d", br_count, mispred_count, br0 + 32'd1, mis0 + 32'd1);
    end
`else
    checks++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      errors++; $display("FAIL blt_counters_off got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
`endif
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_funct3 = 3'b100; BrLt = 1'b0; ex_pred_taken = 1'b1; ex_pc = 32'h220;
    m_tick();
    idle(); fetch_pc = 32'h220; fetch_is_br = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL blt_single_step got=%b exp=0", pred_taken); end
  endtask

  task automatic test_same_index();
    idle();
    fetch_pc = 32'h14; fetch_is_br = 1'b1; fetch_br_target = 32'h54;
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h14; ex_br_target = 32'h54;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_pc !== 32'h18) begin
      errors++; $display("FAIL same_idx_now got=%b/%h exp=0/18", pred_taken, pred_pc);
    end
    m_tick();
    idle(); fetch_pc = 32'h14; fetch_is_br = 1'b1; fetch_br_target = 32'h54;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_pc !== 32'h54) begin
      errors++; $display("FAIL same_idx_next got=%b/%h exp=1/54", pred_taken, pred_pc);
    end
  endtask

  task automatic test_reset_midop();
    idle();
    rst = 1'b1;
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h14; ex_br_target = 32'h54;
    #1;
    checks++; if (PCSel !== 2'd0 || flush !== 1'b0 || redirect_pc !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs got=sel %0d flush %b pc %h exp=0 0 0", PCSel, flush, redirect_pc);
    end
    m_tick();
    rst = 1'b0; idle();
    fetch_pc = 32'h14; fetch_is_br = 1'b1; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_idx5 got=%b exp=0", pred_taken); end
    fetch_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_idx0 got=%b exp=0", pred_taken); end
    checks++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      errors++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      fetch_pc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      fetch_is_br = 1'($urandom_range(0, 1));
      fetch_br_target = $urandom() & 32'hFFFF_FFFE;
      id_is_jal = 1'($urandom_range(0, 1));
      id_jal_target = $urandom();
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_stall = ($urandom_range(0, 3) == 0);
      kind = int'($urandom_range(0, 3));
      ex_is_br = (kind == 1 || kind == 2);
      ex_is_jalr = (kind == 3);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_pred_taken = 1'($urandom_range(0, 1));
      ex_pc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      ex_br_target = $urandom() & 32'hFFFF_FFFE;
      ex_jalr_target = $urandom() & 32'hFFFF_FFFE;
      BrEq = 1'($urandom_range(0, 1));
      BrLt = 1'($urandom_range(0, 1));
      #1;
      m_expect();
      checks++; if (pred_taken !== e_pred) begin errors++; $display("FAIL rnd_pred_taken cyc=%0d got=%b exp=%b", c, pred_taken, e_pred); end
      checks++; if (pred_pc !== e_ppc) begin errors++; $display("FAIL rnd_pred_pc cyc=%0d got=%h exp=%h", c, pred_pc, e_ppc); end
      checks++; if (PCSel !== e_sel) begin errors++; $display("FAIL rnd_pcsel cyc=%0d got=%0d exp=%0d", c, PCSel, e_sel); end
      checks++; if (flush !== e_flush) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, flush, e_flush); end
      if (e_redir) begin
        checks++; if (redirect_pc !== e_rpc) begin errors++; $display("FAIL rnd_redirect cyc=%0d got=%h exp=%h", c, redirect_pc, e_rpc); end
      end
      checks++; if (br_count !== e_brc || mispred_count !== e_mis) begin
        errors++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, br_count, mispred_count, e_brc, e_mis);
      end
      m_tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) m_cnt[k] = 1;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_train_beq();
    test_mispredict_bne();
    test_jal_jalr();
    test_stall();
    test_same_index();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
